// File: rtl/ap_ctrl_perf_monitor.sv
// Per-channel ap_ctrl_chain performance monitor with a registered read port.
// Optional min/max latency tracking is enabled by defining APMON_MINMAX_EN.

module ap_ctrl_perf_monitor_ch #(
  parameter int LAT_W = 16,
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ap_start,
  input  logic             ap_done,
  input  logic             ap_continue,
  input  logic             freeze,
  input  logic             clear,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] txn_cnt,
  output logic [LAT_W-1:0] lat_last,
  output logic [LAT_W-1:0] ii_last,
  output logic [LAT_W-1:0] stall_cnt,
  output logic [LAT_W-1:0] min_lat,
  output logic [LAT_W-1:0] max_lat
);
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, WAIT_CONT = 2'd2} state_t;

  state_t           st, nxt_st;
  logic             start_evt, done_evt, start_seen;
  logic [LAT_W-1:0] lat_cnt, ii_cnt, lat_now;

  function automatic logic [LAT_W-1:0] inc_l(input logic [LAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] inc_c(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign state = st;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)     st <= IDLE;
    else if (clear)   st <= IDLE;
    else if (!freeze) st <= nxt_st;
  end

  // Latency counts the start cycle and the done cycle inclusively.
  always_comb begin
    nxt_st    = st;
    start_evt = 1'b0;
    done_evt  = 1'b0;
    lat_now   = inc_l(lat_cnt);
    case (st)
      IDLE: if (ap_start) begin
        start_evt = 1'b1;
        lat_now   = LAT_W'(1);
        if (ap_done) begin
          done_evt = 1'b1;
          nxt_st   = ap_continue ? IDLE : WAIT_CONT;
        end else begin
          nxt_st = BUSY;
        end
      end
      BUSY: if (ap_done) begin
        done_evt = 1'b1;
        nxt_st   = ap_continue ? IDLE : WAIT_CONT;
      end
      WAIT_CONT: if (ap_continue) nxt_st = IDLE;
      default: nxt_st = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n || clear) begin
      lat_cnt    <= '0;
      ii_cnt     <= '0;
      ii_last    <= '0;
      start_seen <= 1'b0;
      lat_last   <= '0;
      txn_cnt    <= '0;
      stall_cnt  <= '0;
    end else if (!freeze) begin
      if (start_seen) ii_cnt <= inc_l(ii_cnt);
      if (start_evt) begin
        lat_cnt    <= LAT_W'(1);
        ii_last    <= ii_cnt;
        ii_cnt     <= LAT_W'(1);
        start_seen <= 1'b1;
      end
      if (st == BUSY)      lat_cnt   <= inc_l(lat_cnt);
      if (st == WAIT_CONT) stall_cnt <= inc_l(stall_cnt);
      if (done_evt) begin
        lat_last <= lat_now;
        txn_cnt  <= inc_c(txn_cnt);
      end
    end
  end

`ifdef APMON_MINMAX_EN
  logic [LAT_W-1:0] min_r, max_r;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n || clear) begin
      min_r <= '1;
      max_r <= '0;
    end else if (!freeze && done_evt) begin
      if (lat_now < min_r) min_r <= lat_now;
      if (lat_now > max_r) max_r <= lat_now;
    end
  end
  assign min_lat = min_r;
  assign max_lat = max_r;
`else
  assign min_lat = '0;
  assign max_lat = '0;
`endif
endmodule

module ap_ctrl_perf_monitor #(
  parameter int NUM_CH = 2,
  parameter int LAT_W  = 16,
  parameter int CNT_W  = 32,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] ap_start,
  input  logic [NUM_CH-1:0] ap_ready,
  input  logic [NUM_CH-1:0] ap_done,
  input  logic [NUM_CH-1:0] ap_continue,
  input  logic              freeze,
  input  logic              clear,
  input  logic              rd_en,
  input  logic [CH_W-1:0]   rd_ch,
  input  logic [2:0]        rd_sel,
  output logic [CNT_W-1:0]  rd_data,
  output logic              rd_valid
);
  logic [NUM_CH-1:0][1:0]       state;
  logic [NUM_CH-1:0][CNT_W-1:0] txn_cnt;
  logic [NUM_CH-1:0][LAT_W-1:0] lat_last, ii_last, stall_cnt, min_lat, max_lat;
  logic [CNT_W-1:0]             rd_mux;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ap_ctrl_perf_monitor_ch #(.LAT_W(LAT_W), .CNT_W(CNT_W)) u_ch (
      .clock      (clock),
      .reset_n    (reset_n),
      .ap_start   (ap_start[i]),
      .ap_done    (ap_done[i]),
      .ap_continue(ap_continue[i]),
      .freeze     (freeze),
      .clear      (clear),
      .state      (state[i]),
      .txn_cnt    (txn_cnt[i]),
      .lat_last   (lat_last[i]),
      .ii_last    (ii_last[i]),
      .stall_cnt  (stall_cnt[i]),
      .min_lat    (min_lat[i]),
      .max_lat    (max_lat[i])
    );
  end

  always_comb begin
    rd_mux = '0;
    if (32'(rd_ch) < NUM_CH) begin
      case (rd_sel)
        3'd0: rd_mux = txn_cnt[rd_ch];
        3'd1: rd_mux = CNT_W'(lat_last[rd_ch]);
        3'd2: rd_mux = CNT_W'(ii_last[rd_ch]);
        3'd3: rd_mux = CNT_W'(stall_cnt[rd_ch]);
        3'd4: rd_mux = CNT_W'(min_lat[rd_ch]);
        3'd5: rd_mux = CNT_W'(max_lat[rd_ch]);
        3'd6: rd_mux = CNT_W'({ap_ready[rd_ch], ap_done[rd_ch], ap_start[rd_ch], state[rd_ch]});
        default: rd_mux = '0;
      endcase
    end
  end

  // Capturing the mux before the counters' edge returns pre-update values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_mux;
    end
  end
endmodule

// File: tb/tb_ap_ctrl_perf_monitor.sv
// Scoreboard bench: expected read data queued at rd_en, compared when rd_valid returns.
module tb_ap_ctrl_perf_monitor;
`ifdef APMON_MINMAX_EN
  localparam bit MM = 1'b1;
`else
  localparam bit MM = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  ap_start = '0, ap_ready = '0, ap_done = '0, ap_continue = 2'b11;
  logic [0:0]  s4 = '0, r4 = '0, d4 = '0, c4 = 1'b1;
  logic        freeze = 1'b0, clear = 1'b0;
  logic        rd_en = 1'b0, rd_en4 = 1'b0;
  logic [0:0]  rd_ch = '0;
  logic [2:0]  rd_sel = '0;
  logic [31:0] rd_data, rd_data4;
  logic        rd_valid, rd_valid4;
  logic        exp_vld = 1'b0, exp_vld4 = 1'b0;

  logic [31:0] exp_q[$], exp4_q[$];
  string       tag_q[$], tag4_q[$];
  int          n_tests = 0, n_fail = 0;

  always #5 clock = ~clock;

  ap_ctrl_perf_monitor #(.NUM_CH(2), .LAT_W(16), .CNT_W(32)) dut (
    .clock(clock), .reset_n(reset_n), .ap_start(ap_start), .ap_ready(ap_ready),
    .ap_done(ap_done), .ap_continue(ap_continue), .freeze(freeze), .clear(clear),
    .rd_en(rd_en), .rd_ch(rd_ch), .rd_sel(rd_sel), .rd_data(rd_data), .rd_valid(rd_valid));

  ap_ctrl_perf_monitor #(.NUM_CH(1), .LAT_W(4), .CNT_W(32)) dut4 (
    .clock(clock), .reset_n(reset_n), .ap_start(s4), .ap_ready(r4),
    .ap_done(d4), .ap_continue(c4), .freeze(freeze), .clear(clear),
    .rd_en(rd_en4), .rd_ch(rd_ch), .rd_sel(rd_sel), .rd_data(rd_data4), .rd_valid(rd_valid4));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic rd(input bit u4, input logic ch, input logic [2:0] sel,
                    input logic [31:0] exp, input string tag);
    rd_ch  = ch;
    rd_sel = sel;
    if (u4) begin rd_en4 = 1'b1; exp4_q.push_back(exp); tag4_q.push_back(tag); end
    else    begin rd_en  = 1'b1; exp_q.push_back(exp);  tag_q.push_back(tag);  end
    tick;
    rd_en  = 1'b0;
    rd_en4 = 1'b0;
  endtask

  // One transaction on dut channel ch, latency lat >= 2, continue already high.
  task automatic run(input int ch, input int lat);
    ap_start[ch] = 1'b1;
    tick;
    ap_start[ch] = 1'b0;
    repeat (lat - 2) tick;
    ap_done[ch] = 1'b1;
    tick;
    ap_done[ch] = 1'b0;
  endtask

  always @(posedge clock) begin
    exp_vld  <= rd_en;
    exp_vld4 <= rd_en4;
  end

  always @(negedge clock) begin
    if (rd_valid || exp_vld) chk("rd_valid", 32'(rd_valid), 32'(exp_vld));
    if (rd_valid4 || exp_vld4) chk("rd_valid4", 32'(rd_valid4), 32'(exp_vld4));
    if (rd_valid && exp_q.size() > 0) chk(tag_q.pop_front(), rd_data, exp_q.pop_front());
    if (rd_valid4 && exp4_q.size() > 0) chk(tag4_q.pop_front(), rd_data4, exp4_q.pop_front());
  end

  initial begin
    repeat (2) tick;
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    reset_n = 1'b1;
    tick;
    rd(0, 0, 0, 0, "rst_txn");
    rd(0, 0, 1, 0, "rst_lat");
    rd(0, 0, 2, 0, "rst_ii");
    rd(0, 0, 3, 0, "rst_stall");
    rd(0, 0, 4, MM ? 32'h0000_ffff : 32'd0, "rst_min");
    rd(0, 0, 5, 0, "rst_max");
    rd(0, 0, 7, 0, "sel7");
    ap_ready[1] = 1'b1;
    rd(0, 1, 6, 32'h10, "status_ready");
    ap_ready[1] = 1'b0;

    // start, done nine cycles later: latency 10
    ap_start[0] = 1'b1;
    tick;
    ap_start[0] = 1'b0;
    rd(0, 0, 6, 32'h1, "t1_busy_state");
    repeat (7) tick;
    ap_done[0] = 1'b1;
    tick;
    ap_done[0] = 1'b0;
    rd(0, 0, 0, 1, "t1_txn");
    rd(0, 0, 1, 10, "t1_lat");
    rd(0, 0, 3, 0, "t1_stall");
    rd(0, 0, 6, 0, "t1_idle");

    // ch1 latency 4, then continue held low until four WAIT_CONT cycles elapse
    ap_start[1] = 1'b1;
    tick;
    ap_start[1] = 1'b0;
    repeat (2) tick;
    ap_done[1] = 1'b1;
    ap_continue[1] = 1'b0;
    tick;
    rd(0, 1, 6, 32'h0a, "t2_wait_state");
    repeat (2) tick;
    ap_continue[1] = 1'b1;
    tick;
    ap_done[1] = 1'b0;
    rd(0, 1, 3, 4, "t2_stall");
    rd(0, 1, 1, 4, "t2_lat");
    rd(0, 1, 0, 1, "t2_txn");
    rd(0, 1, 6, 0, "t2_idle");
    rd(0, 0, 3, 0, "t2_ch0_stall");

    // three back-to-back latency-5 runs with start held high
    ap_start[0] = 1'b1;
    for (int r = 0; r < 3; r++) begin
      repeat (4) tick;
      if (r == 2) ap_start[0] = 1'b0;
      ap_done[0] = 1'b1;
      tick;
      ap_done[0] = 1'b0;
    end
    rd(0, 0, 0, 4, "t3_txn");
    rd(0, 0, 1, 5, "t3_lat");
    rd(0, 0, 2, 5, "t3_ii");

    // latencies 7,3,12 on ch1 (earlier 4 lies inside the range)
    run(1, 7);
    run(1, 3);
    run(1, 12);
    rd(0, 1, 1, 12, "t5_lat");
    rd(0, 1, 0, 4, "t5_txn");
    rd(0, 1, 4, MM ? 32'd3 : 32'd0, "t5_min");
    rd(0, 1, 5, MM ? 32'd12 : 32'd0, "t5_max");
    ap_start[1] = 1'b1;
    ap_done[1] = 1'b1;
    tick;
    ap_start[1] = 1'b0;
    ap_done[1] = 1'b0;
    rd(0, 1, 1, 1, "lat1_lat");
    rd(0, 1, 0, 5, "lat1_txn");
    rd(0, 1, 4, MM ? 32'd1 : 32'd0, "lat1_min");
    rd(0, 1, 3, 4, "lat1_stall");

    // freeze six cycles mid-BUSY: latency stays 5
    ap_start[0] = 1'b1;
    tick;
    ap_start[0] = 1'b0;
    repeat (2) tick;
    freeze = 1'b1;
    rd(0, 0, 0, 4, "t6_frozen_txn");
    repeat (5) tick;
    freeze = 1'b0;
    tick;
    ap_done[0] = 1'b1;
    tick;
    ap_done[0] = 1'b0;
    rd(0, 0, 1, 5, "t6_lat");
    rd(0, 0, 0, 5, "t6_txn");

    // LAT_W=4: 20-cycle run saturates, next start sees saturated interval
    s4 = 1'b1;
    tick;
    s4 = 1'b0;
    repeat (18) tick;
    d4 = 1'b1;
    tick;
    d4 = 1'b0;
    rd(1, 0, 1, 15, "t4_lat_sat");
    rd(1, 1, 1, 0, "t4_ch_oob");
    s4 = 1'b1;
    tick;
    s4 = 1'b0;
    d4 = 1'b1;
    tick;
    d4 = 1'b0;
    rd(1, 0, 2, 15, "t4_ii_sat");
    rd(1, 0, 1, 2, "t4_lat2");
    rd(1, 0, 0, 2, "t4_txn");
    rd(1, 0, 4, MM ? 32'd2 : 32'd0, "t4_min");
    rd(1, 0, 5, MM ? 32'd15 : 32'd0, "t4_max");

    // clear wins over freeze and drops the in-flight ch1 transaction
    ap_start[1] = 1'b1;
    tick;
    ap_start[1] = 1'b0;
    tick;
    freeze = 1'b1;
    clear = 1'b1;
    tick;
    freeze = 1'b0;
    clear = 1'b0;
    ap_done[1] = 1'b1;
    tick;
    ap_done[1] = 1'b0;
    rd(0, 1, 0, 0, "clr_txn1");
    rd(0, 1, 6, 0, "clr_state1");
    rd(0, 0, 0, 0, "clr_txn0");
    rd(0, 0, 1, 0, "clr_lat0");
    rd(0, 0, 4, MM ? 32'h0000_ffff : 32'd0, "clr_min0");
    rd(1, 0, 0, 0, "clr4_txn");
    rd(1, 0, 1, 0, "clr4_lat");
    rd(1, 0, 2, 0, "clr4_ii");
    rd(1, 0, 4, MM ? 32'hf : 32'd0, "clr4_min");

    // async reset mid-run
    run(0, 6);
    rd(0, 0, 1, 6, "pre_rst_lat");
    ap_start[0] = 1'b1;
    tick;
    ap_start[0] = 1'b0;
    repeat (3) tick;
    reset_n = 1'b0;
    #1;
    chk("async_rd_data", rd_data, 32'd0);
    chk("async_rd_valid", 32'(rd_valid), 32'd0);
    repeat (2) tick;
    reset_n = 1'b1;
    tick;
    rd(0, 0, 6, 0, "post_rst_state");
    rd(0, 0, 1, 0, "post_rst_lat");
    rd(0, 0, 0, 0, "post_rst_txn");

    repeat (3) tick;
    chk("drain", 32'(exp_q.size() + exp4_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
